// File: rtl/majority_pkg.sv
// Shared definitions for the majority-voter self-test (majority_bist).
//   bist_state_e : FSM state type for the sequencer
//   PatternW     : width of the voter pattern index {c,b,a}
//   ErrW         : width of the saturating mismatch counter
//   majority()   : reference 2-of-3 vote used to form the expected result
package majority_pkg;

  localparam int unsigned PatternW = 3;
  localparam int unsigned ErrW     = 4;

  typedef enum logic [2:0] {
    StIdle,
    StApply,
    StSettle,
    StSample,
    StDone
  } bist_state_e;

  // Pattern bit 0 is input a, bit 1 is b, bit 2 is c.
  function automatic logic majority(input logic [PatternW-1:0] p);
    return (p[0] & p[1]) | (p[0] & p[2]) | (p[1] & p[2]);
  endfunction

endpackage

// File: rtl/bist_settle_cnt.sv
// Loadable down-counter that times the settle window of each pattern.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset (count -> 0)
//   load     : load load_val this cycle (priority over en)
//   en       : decrement while non-zero
//   load_val : value loaded on load
//   tc       : terminal count, high while the count is zero
module bist_settle_cnt #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [Width-1:0] load_val,
  output logic             tc
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/majority_bist.sv
// Built-in self-test sequencer for a 3-input majority voter.
// Walks patterns 0..PATTERN_LAST onto vote_{c,b,a}, waits SETTLE_CYCLES
// (including the dut_result input register), then compares the voter output
// against the reference majority.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : level-sampled run request (ignored while busy)
//   vote_a/b/c          : pattern driven to the voter under test
//   dut_result          : voter output returned from the voter under test
//   busy, done, pass    : run status; pass valid while done
//   err_count           : mismatching patterns, saturating at 15
//   first_fail          : index of the first mismatch, 0 if none
// Build option: define MAJORITY_BIST_LOOP_EN to restart a passing run
// automatically after one cycle in DONE (continuous soak).
module majority_bist
  import majority_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned PATTERN_LAST  = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                vote_a,
  output logic                vote_b,
  output logic                vote_c,
  input  logic                dut_result,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ErrW-1:0]     err_count,
  output logic [PatternW-1:0] first_fail
);

  localparam logic [PatternW-1:0] LastIdx    = PatternW'(PATTERN_LAST);
  // The result register eats one settle cycle, so the timer covers the rest.
  localparam logic [3:0]          SettleLoad = 4'(SETTLE_CYCLES - 1);

  bist_state_e         state_d, state_q;
  logic [PatternW-1:0] idx_d, idx_q;
  logic [ErrW-1:0]     err_d, err_q;
  logic [PatternW-1:0] ff_d, ff_q;
  logic                pass_d, pass_q;
  logic                res_q;
  logic                cnt_load, cnt_en, cnt_tc;
  logic                launch, mismatch;

  bist_settle_cnt #(
    .Width(4)
  ) u_settle_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cnt_load),
    .en      (cnt_en),
    .load_val(SettleLoad),
    .tc      (cnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    err_d    = err_q;
    ff_d     = ff_q;
    pass_d   = pass_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    launch   = 1'b0;
    mismatch = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) launch = 1'b1;
      end
      StApply: begin
        cnt_load = 1'b1;
        state_d  = StSettle;
      end
      StSettle: begin
        if (cnt_tc) state_d = StSample;
        else        cnt_en  = 1'b1;
      end
      StSample: begin
        mismatch = (res_q != majority(idx_q));
        if (mismatch) begin
          if (err_q == '0) ff_d = idx_q;
          if (err_q != '1) err_d = err_q + ErrW'(1);
        end
        if (idx_q == LastIdx) begin
          state_d = StDone;
          pass_d  = (err_d == '0);
        end else begin
          idx_d   = idx_q + PatternW'(1);
          state_d = StApply;
        end
      end
      StDone: begin
        if (start) launch = 1'b1;
`ifdef MAJORITY_BIST_LOOP_EN
        else if (pass_q) launch = 1'b1;
`endif
      end
      default: state_d = StIdle;
    endcase
    if (launch) begin
      state_d = StApply;
      idx_d   = '0;
      err_d   = '0;
      ff_d    = '0;
      pass_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      pass_q  <= 1'b0;
      res_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      pass_q  <= pass_d;
      res_q   <= dut_result;
    end
  end

  always_comb begin
    busy = (state_q == StApply) || (state_q == StSettle) || (state_q == StSample);
    done = (state_q == StDone);
    {vote_c, vote_b, vote_a} = busy ? idx_q : '0;
  end

  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_majority_bist.sv
// Directed bench for majority_bist with a switchable voter model.
module tb_majority_bist;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       vote_a, vote_b, vote_c;
  logic       dut_result;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] first_fail;

  // 0: correct voter, 1: AND of a,b,c, 2: output tied high
  int mode = 0;
  int n_checks = 0;
  int n_errors = 0;
  int n;

  always #5 clk = ~clk;

  always_comb begin
    dut_result = 1'b0;
    case (mode)
      0: dut_result = (vote_a & vote_b) | (vote_a & vote_c) | (vote_b & vote_c);
      1: dut_result = vote_a & vote_b & vote_c;
      default: dut_result = 1'b1;
    endcase
  end

  majority_bist dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .vote_a    (vote_a),
    .vote_b    (vote_b),
    .vote_c    (vote_c),
    .dut_result(dut_result),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .first_fail(first_fail)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start pulse; returns with the accepting edge just passed.
  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int n_out);
    n_out = n0;
    while (!done && n_out < 200) begin
      tick();
      n_out++;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_err"}, 32'(err_count), 32'd0);
    check({tag, "_ff"}, 32'(first_fail), 32'd0);
    check({tag, "_votes"}, 32'({vote_c, vote_b, vote_a}), 32'd0);
  endtask

  initial begin
    #12;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Correct voter: 48-cycle run, clean pass.
    mode = 0;
    launch();
    check("run0_busy", 32'(busy), 32'd1);
    wait_done(0, n);
    check("run0_latency", 32'(n), 32'd48);
    check("run0_busy_end", 32'(busy), 32'd0);
    check("run0_pass", 32'(pass), 32'd1);
    check("run0_err", 32'(err_count), 32'd0);
    check("run0_ff", 32'(first_fail), 32'd0);
    check("run0_votes", 32'({vote_c, vote_b, vote_a}), 32'd0);

    // AND voter: patterns 3,5,6 mismatch.
    mode = 1;
    launch();
    wait_done(0, n);
    check("and_pass", 32'(pass), 32'd0);
    check("and_err", 32'(err_count), 32'd3);
    check("and_ff", 32'(first_fail), 32'd3);

    // Output tied high: patterns 0,1,2,4 mismatch.
    mode = 2;
    launch();
    wait_done(0, n);
    check("tie1_pass", 32'(pass), 32'd0);
    check("tie1_err", 32'(err_count), 32'd4);
    check("tie1_ff", 32'(first_fail), 32'd0);

    // Start re-asserted mid-run is ignored.
    mode = 1;
    launch();
    repeat (9) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("reassert_busy", 32'(busy), 32'd1);
    wait_done(10, n);
    check("reassert_latency", 32'(n), 32'd48);
    check("reassert_err", 32'(err_count), 32'd3);

    // Start held in DONE relaunches next cycle and clears the old result.
    mode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("relaunch_busy", 32'(busy), 32'd1);
    check("relaunch_done", 32'(done), 32'd0);
    check("relaunch_err", 32'(err_count), 32'd0);
    check("relaunch_ff", 32'(first_fail), 32'd0);
    wait_done(0, n);
    check("relaunch_latency", 32'(n), 32'd48);
    check("relaunch_pass", 32'(pass), 32'd1);

`ifdef MAJORITY_BIST_LOOP_EN
    tick();
    check("loop_restart_busy", 32'(busy), 32'd1);
    wait_done(0, n);
    check("loop_latency", 32'(n), 32'd48);
    check("loop_pass", 32'(pass), 32'd1);
`else
    repeat (3) tick();
    check("hold_done", 32'(done), 32'd1);
    check("hold_busy", 32'(busy), 32'd0);

    // Reset during pattern 5 settle, after one failing pattern recorded.
    mode = 1;
    launch();
    repeat (30) tick();
    check("p5_votes", 32'({vote_c, vote_b, vote_a}), 32'd5);
    check("p5_err", 32'(err_count), 32'd1);
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    tick();
    check("midreset_stay_idle", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    check("after_reset_idle", 32'(busy), 32'd0);
    mode = 0;
    launch();
    wait_done(0, n);
    check("after_reset_latency", 32'(n), 32'd48);
    check("after_reset_pass", 32'(pass), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/majority_bist.md
MAJORITY_BIST -- requirements
Module: majority_bist

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, number of clock cycles the DUT result settles after each pattern is applied (legal 1..15).
REQ-002 SHALL have parameter PATTERN_LAST, default 7, index of the last 3-bit pattern exercised (patterns 0..PATTERN_LAST, legal 0..7).
REQ-003 clk  input  1  rising-edge system clock; the block's only clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  level-sampled request to begin a self-test run.
REQ-006 vote_a  output  1  voter input a (SW0 position) driven to the majority voter under test.
REQ-007 vote_b  output  1  voter input b (SW1 position).
REQ-008 vote_c  output  1  voter input c (SW2 position).
REQ-009 dut_result  input  1  voter output (LED position) returned from the voter under test.
REQ-010 busy  output  1  high while a run is in progress.
REQ-011 done  output  1  high once a run has completed; held until the next run starts.
REQ-012 pass  output  1  valid when done=1; 1 when every pattern matched.
REQ-013 err_count  output  4  number of mismatching patterns in the current/last run, saturating at 15.
REQ-014 first_fail  output  3  pattern index of the first mismatch; 0 if none.

Function
REQ-015 FSM states SHALL be IDLE, APPLY, SETTLE, SAMPLE, DONE.
REQ-016 IDLE or DONE with start=1 SHALL go to APPLY on the next edge, clear err_count, first_fail, pass, done, and load pattern index 0.
REQ-017 {vote_c,vote_b,vote_a} SHALL equal the current 3-bit pattern index in APPLY, SETTLE and SAMPLE; 3'b000 in IDLE and DONE.
REQ-018 APPLY SHALL last 1 cycle; SETTLE SHALL last exactly SETTLE_CYCLES cycles; SAMPLE SHALL last 1 cycle.
REQ-019 In SAMPLE, dut_result SHALL be compared with the expected majority ((a&b)|(a&c)|(b&c)) of the current pattern.
REQ-020 On mismatch, err_count SHALL increment (saturating at 15); first_fail SHALL latch the index only on the first mismatch of the run.
REQ-021 After SAMPLE, index < PATTERN_LAST SHALL increment and go to APPLY; index = PATTERN_LAST SHALL go to DONE with no wrap-around.
REQ-022 Run latency from the start-accepting edge to DONE entry SHALL be (PATTERN_LAST+1)*(SETTLE_CYCLES+2) cycles.
REQ-023 busy SHALL be 1 exactly in APPLY, SETTLE, SAMPLE; done SHALL be 1 exactly in DONE; pass SHALL be (err_count==0) registered on DONE entry.
REQ-024 start while busy=1 SHALL be ignored; start held high in DONE SHALL immediately launch a new run.
REQ-025 dut_result SHALL be registered once before comparison; the register SHALL be counted within SETTLE_CYCLES.

Reset
REQ-026 rst_n=0 SHALL asynchronously force IDLE, index 0, vote_a/b/c=0, busy=0, done=0, pass=0, err_count=0, first_fail=0.
REQ-027 Reset asserted mid-run SHALL abort the run with no partial result retained; a run SHALL start only via start after rst_n deasserts.

Configuration
REQ-028 Macro MAJORITY_BIST_LOOP_EN defined: DONE with pass=1 SHALL auto-restart at APPLY after 1 cycle (continuous soak); pass=0 SHALL stop in DONE.
REQ-029 Macro MAJORITY_BIST_LOOP_EN undefined: DONE SHALL hold until start; no auto-restart logic compiled.

Structure
REQ-030 Shared package majority_pkg SHALL hold the FSM state type, the pattern width constant (3), the err_count width (4), and a majority function used by the expected-value calculation.
REQ-031 A sub-module bist_settle_cnt (loadable down-counter, terminal-count output) SHALL implement the SETTLE timer; the rest SHALL be flat.

Verification
REQ-032 Correct voter attached, defaults, start pulse -> busy for 48 cycles, then done=1, pass=1, err_count=0, first_fail=0.
REQ-033 Voter replaced by an AND of a,b,c -> pass=0, err_count=3 (patterns 3,5,6), first_fail=3.
REQ-034 dut_result tied to 1 -> err_count=4 (patterns 0,1,2,4), first_fail=0, pass=0.
REQ-035 rst_n pulsed low during pattern 5 SETTLE -> all outputs 0 at once, IDLE; a new start then yields a full 48-cycle run.
REQ-036 start re-asserted at cycle 10 of a run -> run unaffected, done at cycle 48; start held high in DONE -> new run begins next cycle.
REQ-037 MAJORITY_BIST_LOOP_EN defined, correct voter -> DONE for 1 cycle, then repeated 48-cycle runs with no start.
